hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable.
- Detects load-use hazards, squashes wrong-path instructions on jumps and taken branches, and freezes the pipeline during multi-cycle EX ops and data-memory wait states.
- Keeps saturating performance counters and a memory-wait watchdog.

Parameters:
- CNT_W, 32: width of the stall_cycles and flush_count counters.
- MEM_TIMEOUT, 255: maximum consecutive MEM_WAIT cycles before mem_timeout fires.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_uses_rs  in  1  ID instruction reads rs.
- ID_uses_rt  in  1  ID instruction reads rt.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_rd  in  5  destination register of the instruction in EX.
- ID_jump  in  1  jump decoded in ID.
- EX_branch_taken  in  1  branch resolved taken in EX.
- EX_mc_start  in  1  single-cycle pulse: a multi-cycle op (mul/div) has entered EX.
- EX_mc_done  in  1  multi-cycle op has finished; may coincide with EX_mc_start.
- MEM_req  in  1  MEM stage is accessing data memory.
- MEM_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC update enable.
- IF_ID_stall  out  1  hold IF/ID.
- IF_ID_flush  out  1  clear IF/ID.
- ID_EX_stall  out  1  hold ID/EX.
- ID_EX_flush  out  1  clear ID/EX (insert bubble).
- EX_MEM_stall  out  1  hold EX/MEM.
- EX_MEM_flush  out  1  clear EX/MEM.
- MEM_WB_flush  out  1  clear MEM/WB.
- mem_timeout  out  1  one-cycle pulse when the watchdog fires.
- stall_cycles  out  CNT_W  count of cycles with PC_write==0.
- flush_count  out  CNT_W  count of cycles with IF_ID_flush==1.

Behaviour:
- FSM states: RUN, MC_WAIT, MEM_WAIT. The state register, watchdog counter and perf counters are sequential. All control outputs are combinational from state and inputs, so they take effect at the next clock edge.
- Reset (reset==0), asynchronous: state=RUN, watchdog=0, counters=0, mem_timeout=0. While reset is low, all control outputs are 0.
- Definitions:
  - mem_wait = MEM_req && !MEM_ready.
  - load_use = EX_MemRead && EX_rd!=0 && ((ID_uses_rs && ID_rs==EX_rd) || (ID_uses_rt && ID_rt==EX_rd)).
  - mc_wait = (state==MC_WAIT || EX_mc_start) && !EX_mc_done.
- Default outputs: PC_write=1, all stall/flush=0.
- Priority, highest first; exactly one row applies per cycle:
  1. mem_wait: PC_write=0, IF_ID_stall=1, ID_EX_stall=1, EX_MEM_stall=1, MEM_WB_flush=1. Any pending branch/jump stays frozen and is handled once the wait ends.
  2. mc_wait: PC_write=0, IF_ID_stall=1, ID_EX_stall=1, EX_MEM_flush=1.
  3. EX_branch_taken: IF_ID_flush=1, ID_EX_flush=1, PC_write=1. This overrides load_use because the ID instruction is squashed.
  4. load_use: PC_write=0, IF_ID_stall=1, ID_EX_flush=1. Exactly one bubble; the next cycle the load is in MEM and load_use is false.
  5. ID_jump: IF_ID_flush=1, PC_write=1.
- Transitions:
  - Any state -> MEM_WAIT when mem_wait. MEM_WAIT -> RUN when !mem_wait.
  - RUN -> MC_WAIT on EX_mc_start && !EX_mc_done && !mem_wait. MC_WAIT -> RUN on EX_mc_done.
  - Simultaneous mem_wait and mc wait: MEM_WAIT wins. A flag remembers the pending multi-cycle op, and the FSM resumes in MC_WAIT (not RUN) unless EX_mc_done was seen during MEM_WAIT.
- Watchdog:
  - Increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_timeout pulses for 1 cycle and the watchdog clears.
  - The stall continues while MEM_ready stays low; recovery is the system's responsibility.
- Counters: stall_cycles increments on each cycle with PC_write==0; flush_count increments on each cycle with IF_ID_flush==1. Both saturate at all-ones.
- EX_branch_taken together with EX_mc_start is illegal (single EX slot). The priority rule above still yields a deterministic result (mc_wait wins).

Decomposition:
- Shared package holds the state encoding (RUN=2'd0, MC_WAIT=2'd1, MEM_WAIT=2'd2), register-index width 5, and the zero-register constant.
- One sub-module is natural: sat_counter, parameterised by width with an inc input; instantiated twice.

Test Plan:
- load_use: EX_MemRead=1, EX_rd=8, ID_rs=8, ID_uses_rs=1 -> one cycle of PC_write=0, IF_ID_stall=1, ID_EX_flush=1; stall_cycles goes 0->1.
- Taken branch with load_use the same cycle -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1; flush_count +1; no stall.
- EX_mc_start pulse, EX_mc_done 4 cycles later -> exactly 4 stalled cycles (IF_ID_stall=1, EX_MEM_flush=1); mc_start with mc_done in the same cycle -> 0 stalled cycles.
- MEM_req=1, MEM_ready=0 for 3 cycles during MC_WAIT -> all stages frozen for 3 cycles, then FSM resumes in MC_WAIT.
- MEM_TIMEOUT=4, MEM_ready held low for 10 cycles -> mem_timeout pulses on the 4th and 8th wait cycles.
- Assert reset low mid-MC_WAIT -> immediately state=RUN, all outputs 0, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM encoding, register-index width and the per-cycle control bundle.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{default: 1'b0};

    function automatic logic reg_hit(input logic uses, input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard sequencer: hazard sources in, stall/flush controls out.
// The pipeline holds the master modport, the sequencer the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import hazard_ctrl_pkg::*;

    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_uses_rs;
    logic             ID_uses_rt;
    logic             EX_MemRead;
    logic [REG_W-1:0] EX_rd;
    logic             ID_jump;
    logic             EX_branch_taken;
    logic             EX_mc_start;
    logic             EX_mc_done;
    logic             MEM_req;
    logic             MEM_ready;
    logic             PC_write;
    logic             IF_ID_stall;
    logic             IF_ID_flush;
    logic             ID_EX_stall;
    logic             ID_EX_flush;
    logic             EX_MEM_stall;
    logic             EX_MEM_flush;
    logic             MEM_WB_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_rd, ID_jump,
               EX_branch_taken, EX_mc_start, EX_mc_done, MEM_req, MEM_ready,
        input  PC_write, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_MemRead, EX_rd, ID_jump,
               EX_branch_taken, EX_mc_start, EX_mc_done, MEM_req, MEM_ready,
        output PC_write, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-wait watchdog and perf counters.
// Controls are combinational from state and inputs; they act on the next clock edge.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_t          state_r;
    logic            mc_pend_r;
    logic [WD_W-1:0] wd_r;
    logic            mem_wait_s;
    logic            load_use_s;
    logic            mc_wait_s;
    logic            wd_last_s;
    ctrl_t           prio_s;
    ctrl_t           out_s;

    assign mem_wait_s = hz.MEM_req && !hz.MEM_ready;
    assign load_use_s = hz.EX_MemRead && (hz.EX_rd != ZERO_REG) &&
                        (reg_hit(hz.ID_uses_rs, hz.ID_rs, hz.EX_rd) ||
                         reg_hit(hz.ID_uses_rt, hz.ID_rt, hz.EX_rd));
    // A multi-cycle op parked behind a memory wait still counts as in flight.
    assign mc_wait_s  = ((state_r == MC_WAIT) || ((state_r == MEM_WAIT) && mc_pend_r) ||
                         hz.EX_mc_start) && !hz.EX_mc_done;
    assign wd_last_s  = (wd_r == WD_LAST);

    // Pick exactly one hazard response per cycle, highest priority first.
    always_comb begin
        prio_s          = CTRL_NONE;
        prio_s.pc_write = 1'b1;
        if (mem_wait_s) begin
            prio_s.pc_write     = 1'b0;
            prio_s.if_id_stall  = 1'b1;
            prio_s.id_ex_stall  = 1'b1;
            prio_s.ex_mem_stall = 1'b1;
            prio_s.mem_wb_flush = 1'b1;
        end else if (mc_wait_s) begin
            prio_s.pc_write     = 1'b0;
            prio_s.if_id_stall  = 1'b1;
            prio_s.id_ex_stall  = 1'b1;
            prio_s.ex_mem_flush = 1'b1;
        end else if (hz.EX_branch_taken) begin
            prio_s.if_id_flush  = 1'b1;
            prio_s.id_ex_flush  = 1'b1;
        end else if (load_use_s) begin
            prio_s.pc_write     = 1'b0;
            prio_s.if_id_stall  = 1'b1;
            prio_s.id_ex_flush  = 1'b1;
        end else if (hz.ID_jump) begin
            prio_s.if_id_flush  = 1'b1;
        end else begin
            prio_s.pc_write     = 1'b1;
        end
    end

    assign out_s = reset ? prio_s : CTRL_NONE;

    // FSM: memory wait dominates and remembers a multi-cycle op left pending behind it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= RUN;
            mc_pend_r <= 1'b0;
        end else if (mem_wait_s) begin
            state_r   <= MEM_WAIT;
            mc_pend_r <= mc_wait_s;
        end else if (mc_wait_s) begin
            state_r   <= MC_WAIT;
            mc_pend_r <= 1'b0;
        end else begin
            state_r   <= RUN;
            mc_pend_r <= 1'b0;
        end
    end

    // Watchdog: count consecutive wait cycles, restart after each timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_r <= {WD_W{1'b0}};
        end else if (!mem_wait_s || wd_last_s) begin
            wd_r <= {WD_W{1'b0}};
        end else begin
            wd_r <= wd_r + WD_W'(1);
        end
    end

    assign hz.PC_write     = out_s.pc_write;
    assign hz.IF_ID_stall  = out_s.if_id_stall;
    assign hz.IF_ID_flush  = out_s.if_id_flush;
    assign hz.ID_EX_stall  = out_s.id_ex_stall;
    assign hz.ID_EX_flush  = out_s.id_ex_flush;
    assign hz.EX_MEM_stall = out_s.ex_mem_stall;
    assign hz.EX_MEM_flush = out_s.ex_mem_flush;
    assign hz.MEM_WB_flush = out_s.mem_wb_flush;
    assign hz.mem_timeout  = reset && mem_wait_s && wd_last_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!out_s.pc_write),
        .count (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_s.if_id_flush),
        .count (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle priority table plus multi-cycle sequences.
module tb_hazard_ctrl;
    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 4;

    // {PC_write, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, EX_MEM_flush, MEM_WB_flush}
    localparam logic [7:0] NORM = 8'b1000_0000;
    localparam logic [7:0] MEMW = 8'b0101_0101;
    localparam logic [7:0] MCW  = 8'b0101_0010;
    localparam logic [7:0] BR   = 8'b1010_1000;
    localparam logic [7:0] LU   = 8'b0100_1000;
    localparam logic [7:0] JMP  = 8'b1010_0000;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       memrd;
        logic [4:0] rd;
        logic       jump;
        logic       br;
        logic       mcs;
        logic       mcd;
        logic       mreq;
        logic       mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [7:0] got_ctrl();
        return {hz.PC_write, hz.IF_ID_stall, hz.IF_ID_flush, hz.ID_EX_stall,
                hz.ID_EX_flush, hz.EX_MEM_stall, hz.EX_MEM_flush, hz.MEM_WB_flush};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic memrd, input logic [4:0] rd,
                          input logic jump, input logic br, input logic mcs, input logic mcd,
                          input logic mreq, input logic mrdy);
        hz.ID_rs = rs;  hz.ID_rt = rt;  hz.ID_uses_rs = urs;  hz.ID_uses_rt = urt;
        hz.EX_MemRead = memrd;  hz.EX_rd = rd;  hz.ID_jump = jump;
        hz.EX_branch_taken = br;  hz.EX_mc_start = mcs;  hz.EX_mc_done = mcd;
        hz.MEM_req = mreq;  hz.MEM_ready = mrdy;
    endtask

    task automatic set_ctl(input logic jump, input logic br, input logic mcs, input logic mcd,
                           input logic mreq, input logic mrdy);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, jump, br, mcs, mcd, mreq, mrdy);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input string nm, input logic [7:0] exp, input logic exp_to);
        #1;
        chk({nm, " ctrl"}, {24'd0, got_ctrl()}, {24'd0, exp});
        chk({nm, " timeout"}, {31'd0, hz.mem_timeout}, {31'd0, exp_to});
        if (!exp[7] && (exp_stall != {CNT_W{1'b1}})) exp_stall = exp_stall + 6'd1;
        if (exp[5] && (exp_flush != {CNT_W{1'b1}})) exp_flush = exp_flush + 6'd1;
        @(posedge clk);
        #1;
        chk({nm, " stall_cycles"}, {26'd0, hz.stall_cycles}, {26'd0, exp_stall});
        chk({nm, " flush_count"}, {26'd0, hz.flush_count}, {26'd0, exp_flush});
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[1]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[2]  = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[4]  = '{5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[5]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, JMP};
        vecs[7]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR};
        vecs[8]  = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MEMW};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, JMP};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NORM};
        vecs[13] = '{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LU};
        vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, MEMW};
        vecs[15] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};

        // Reset: controls forced low even with a memory wait on the inputs.
        reset = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_stall = '0;
        exp_flush = '0;
        #2;
        chk("reset ctrl", {24'd0, got_ctrl()}, 32'd0);
        chk("reset timeout", {31'd0, hz.mem_timeout}, 32'd0);
        chk("reset stall_cycles", {26'd0, hz.stall_cycles}, 32'd0);
        chk("reset flush_count", {26'd0, hz.flush_count}, 32'd0);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].memrd, vecs[i].rd,
                   vecs[i].jump, vecs[i].br, vecs[i].mcs, vecs[i].mcd, vecs[i].mreq, vecs[i].mrdy);
            step($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
        end

        // Multi-cycle op: start pulse, done four cycles later -> four stalled cycles.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mc start", MCW, 1'b0);
        for (int k = 1; k < 4; k++) begin
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step($sformatf("mc wait%0d", k), MCW, 1'b0);
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mc done", NORM, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mc after", NORM, 1'b0);

        // Memory wait for three cycles inside MC_WAIT, then resume in MC_WAIT.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mcm start", MCW, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("mcm memwait%0d", k), MEMW, 1'b0);
        end
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mcm resume", MCW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mcm still", MCW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("mcm done", NORM, 1'b0);

        // mc_start coinciding with the first wait cycle is remembered.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("pend enter", MEMW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("pend resume", MCW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("pend done", NORM, 1'b0);

        // mc_done seen during the memory wait: return straight to RUN.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mdw start", MCW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mdw memwait", MEMW, 1'b0);
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mdw exit", JMP, 1'b0);

        // Watchdog: ten wait cycles, timeout on the 4th and 8th.
        for (int k = 1; k <= 10; k++) begin
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("wd cyc%0d", k), MEMW, (k % 4) == 0);
        end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wd release", NORM, 1'b0);

        // Watchdog restarts when the wait is broken.
        for (int k = 0; k < 7; k++) begin
            set_ctl(1'b0, 1'b0, 1'b0, 1'b0, k != 3, 1'b0);
            step($sformatf("wd clr%0d", k), (k == 3) ? NORM : MEMW, 1'b0);
        end

        // Asynchronous reset in the middle of MC_WAIT.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rst mcstart", MCW, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        exp_stall = '0;
        exp_flush = '0;
        chk("midrst ctrl", {24'd0, got_ctrl()}, 32'd0);
        chk("midrst timeout", {31'd0, hz.mem_timeout}, 32'd0);
        chk("midrst stall_cycles", {26'd0, hz.stall_cycles}, 32'd0);
        chk("midrst flush_count", {26'd0, hz.flush_count}, 32'd0);
        @(negedge clk);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step("midrst run", NORM, 1'b0);

        // Counter saturation.
        for (int k = 0; k < 70; k++) begin
            set_in(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step($sformatf("sat lu%0d", k), LU, 1'b0);
        end
        chk("stall saturated", {26'd0, hz.stall_cycles}, 32'd63);
        for (int k = 0; k < 70; k++) begin
            set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step($sformatf("sat jmp%0d", k), JMP, 1'b0);
        end
        chk("flush saturated", {26'd0, hz.flush_count}, 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
